// File: rtl/vend_dispense_sequencer.sv
// -----------------------------------------------------------------------------
// vend_dispense_sequencer
//
// Purpose: sits between the coin/selection front panel and one shared dispense
// mechanism. Accumulates coin credit, arbitrates round-robin among NUM_SLOTS
// selection buttons (only affordable, in-stock, enabled slots compete),
// sequences the mechanism through a start/done handshake, deducts the price,
// and returns coins one per cycle on cancel or on a mechanism timeout.
//
// Optional build macro: AUTO_CHANGE_EN
//   defined   - any credit left after a vend is returned automatically
//   undefined - leftover credit stays available in IDLE
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low
//   coin_in      one coin per cycle while high
//   cancel       request refund of all credit
//   sel_req      selection buttons (level), one per slot
//   stock_empty  per-slot empty flags
//   mech_ready   mechanism can accept a start
//   mech_done    one-cycle pulse, item delivered
//   mech_start   one-cycle start pulse to the mechanism
//   mech_slot    slot being dispensed, valid from mech_start until done
//   item_out     one-cycle pulse after a successful vend
//   refund_pulse one coin returned per high cycle
//   coin_reject  one-cycle pulse, coin not accepted
//   credit       current credit
//   busy         high in any state except IDLE
//   fault        sticky mechanism-timeout flag (cleared only by reset)
// All outputs are registered.
// -----------------------------------------------------------------------------
module vend_dispense_sequencer #(
    parameter int                            NUM_SLOTS    = 4,
    parameter int                            CREDIT_W     = 4,
    parameter logic [NUM_SLOTS*CREDIT_W-1:0] PRICE_VEC    = {4'd5, 4'd3, 4'd2, 4'd1},
    parameter int                            MECH_TIMEOUT = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         coin_in,
    input  logic                         cancel,
    input  logic [NUM_SLOTS-1:0]         sel_req,
    input  logic [NUM_SLOTS-1:0]         stock_empty,
    input  logic                         mech_ready,
    input  logic                         mech_done,
    output logic                         mech_start,
    output logic [$clog2(NUM_SLOTS)-1:0] mech_slot,
    output logic                         item_out,
    output logic                         refund_pulse,
    output logic                         coin_reject,
    output logic [CREDIT_W-1:0]          credit,
    output logic                         busy,
    output logic                         fault
);

    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int TMO_W  = (MECH_TIMEOUT > 1) ? $clog2(MECH_TIMEOUT) : 1;
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = {CREDIT_W{1'b1}};
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(MECH_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_DONE, S_REFUND} state_t;

    state_t              r_state, w_state_nxt;
    logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
    logic [SLOT_W-1:0]   r_ptr, w_ptr_nxt;
    logic [SLOT_W-1:0]   r_slot, w_slot_nxt;
    logic [TMO_W-1:0]    r_tmo, w_tmo_nxt;
    logic                r_fault, w_fault_nxt;
    logic                r_start, w_start_nxt;
    logic                r_item, w_item_nxt;
    logic                r_refund, w_refund_nxt;
    logic                r_reject, w_reject_nxt;
    logic                r_busy;

    logic [NUM_SLOTS-1:0] w_elig;
    logic                 w_any_elig;
    logic [SLOT_W-1:0]    w_grant;

    function automatic logic [CREDIT_W-1:0] price_of(input logic [SLOT_W-1:0] idx);
        return PRICE_VEC[int'(idx)*CREDIT_W +: CREDIT_W];
    endfunction

    // (base + ofs) mod NUM_SLOTS without relying on a power-of-two slot count
    function automatic logic [SLOT_W-1:0] wrap_idx(input logic [SLOT_W-1:0] base, input int ofs);
        int sum;
        sum = int'(base) + ofs;
        if (sum >= NUM_SLOTS) sum = sum - NUM_SLOTS;
        return SLOT_W'(sum);
    endfunction

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_elig[i] = sel_req[i] & ~stock_empty[i]
                      & (price_of(SLOT_W'(i)) != '0)
                      & (r_credit >= price_of(SLOT_W'(i)));
        end
    end

    // Scan from the farthest offset back to the pointer so the nearest
    // eligible slot at or after the pointer is the last one written.
    always_comb begin
        w_any_elig = 1'b0;
        w_grant    = '0;
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            if (w_elig[wrap_idx(r_ptr, k)]) begin
                w_any_elig = 1'b1;
                w_grant    = wrap_idx(r_ptr, k);
            end
        end
    end

`ifdef AUTO_CHANGE_EN
    logic [CREDIT_W-1:0] w_remain;
    assign w_remain = r_credit - price_of(r_slot);
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_ptr_nxt    = r_ptr;
        w_slot_nxt   = r_slot;
        w_tmo_nxt    = r_tmo;
        w_fault_nxt  = r_fault;
        w_start_nxt  = 1'b0;
        w_item_nxt   = 1'b0;
        w_refund_nxt = 1'b0;
        // A coin is rejected unless the IDLE coin path below accepts it.
        w_reject_nxt = coin_in;

        case (r_state)
            S_IDLE: begin
                if (cancel) begin
                    if (r_credit != '0) w_state_nxt = S_REFUND;
                end else if (|sel_req) begin
                    if (w_any_elig && !r_fault) begin
                        w_slot_nxt  = w_grant;
                        w_state_nxt = S_START;
                    end
                end else if (coin_in && !r_fault && (r_credit != CREDIT_MAX)) begin
                    w_credit_nxt = r_credit + 1'b1;
                    w_reject_nxt = 1'b0;
                end
            end
            S_START: begin
                if (mech_ready) begin
                    w_start_nxt = 1'b1;
                    w_tmo_nxt   = '0;
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (mech_done) begin
                    w_credit_nxt = r_credit - price_of(r_slot);
                    w_item_nxt   = 1'b1;
                    w_ptr_nxt    = wrap_idx(r_slot, 1);
                    w_tmo_nxt    = '0;
`ifdef AUTO_CHANGE_EN
                    w_state_nxt  = (w_remain != '0) ? S_REFUND : S_IDLE;
`else
                    w_state_nxt  = S_IDLE;
`endif
                end else if (r_tmo == TMO_LAST) begin
                    w_fault_nxt = 1'b1;
                    w_tmo_nxt   = '0;
                    w_state_nxt = S_REFUND;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
            end
            S_REFUND: begin
                if (r_credit != '0) begin
                    w_refund_nxt = 1'b1;
                    w_credit_nxt = r_credit - 1'b1;
                    if (r_credit == CREDIT_W'(1)) w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_credit <= '0;
            r_ptr    <= '0;
            r_slot   <= '0;
            r_tmo    <= '0;
            r_fault  <= 1'b0;
            r_start  <= 1'b0;
            r_item   <= 1'b0;
            r_refund <= 1'b0;
            r_reject <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_credit <= w_credit_nxt;
            r_ptr    <= w_ptr_nxt;
            r_slot   <= w_slot_nxt;
            r_tmo    <= w_tmo_nxt;
            r_fault  <= w_fault_nxt;
            r_start  <= w_start_nxt;
            r_item   <= w_item_nxt;
            r_refund <= w_refund_nxt;
            r_reject <= w_reject_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
        end
    end

    assign mech_start   = r_start;
    assign mech_slot    = r_slot;
    assign item_out     = r_item;
    assign refund_pulse = r_refund;
    assign coin_reject  = r_reject;
    assign credit       = r_credit;
    assign busy         = r_busy;
    assign fault        = r_fault;

endmodule

// File: tb/tb_vend_dispense_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vend_dispense_sequencer
//
// Self-checking bench for vend_dispense_sequencer (default parameters).
// Directed scenarios plus a randomized transaction sequence, checked against a
// transaction-level model: credit as an integer, a round-robin pointer, a
// price table and a sticky fault flag.
// -----------------------------------------------------------------------------
module tb_vend_dispense_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       coin_in = 1'b0;
    logic       cancel = 1'b0;
    logic [3:0] sel_req = 4'b0;
    logic [3:0] stock_empty = 4'b0;
    logic       mech_ready = 1'b0;
    logic       mech_done = 1'b0;
    logic       mech_start;
    logic [1:0] mech_slot;
    logic       item_out;
    logic       refund_pulse;
    logic       coin_reject;
    logic [3:0] credit;
    logic       busy;
    logic       fault;

    vend_dispense_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .coin_in      (coin_in),
        .cancel       (cancel),
        .sel_req      (sel_req),
        .stock_empty  (stock_empty),
        .mech_ready   (mech_ready),
        .mech_done    (mech_done),
        .mech_start   (mech_start),
        .mech_slot    (mech_slot),
        .item_out     (item_out),
        .refund_pulse (refund_pulse),
        .coin_reject  (coin_reject),
        .credit       (credit),
        .busy         (busy),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int PRICES [4] = '{1, 2, 3, 5};
    int m_credit = 0;
    int m_ptr    = 0;
    bit m_fault  = 1'b0;

    // Pulse counters, sampled shortly after each rising edge
    int cnt_refund = 0;
    int cnt_item   = 0;
    int cnt_start  = 0;
    int cnt_reject = 0;

    always @(posedge clk) begin
        #1;
        if (refund_pulse === 1'b1) cnt_refund++;
        if (item_out === 1'b1)     cnt_item++;
        if (mech_start === 1'b1)   cnt_start++;
        if (coin_reject === 1'b1)  cnt_reject++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        m_credit = 0;
        m_ptr    = 0;
        m_fault  = 1'b0;
    endtask

    function automatic int model_grant(input logic [3:0] mask, input logic [3:0] empty);
        int s;
        if (m_fault) return -1;
        for (int k = 0; k < 4; k++) begin
            s = (m_ptr + k) % 4;
            if (mask[s] && !empty[s] && m_credit >= PRICES[s]) return s;
        end
        return -1;
    endfunction

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (busy === 1'b1 && n < max) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout: busy=%0b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic insert_coins(input int n);
        int b_rej, exp_rej;
        b_rej   = cnt_reject;
        exp_rej = 0;
        for (int i = 0; i < n; i++) begin
            coin_in = 1'b1;
            tick();
            if (m_fault || m_credit == 15) exp_rej++;
            else m_credit++;
        end
        coin_in = 1'b0;
        checks++;
        if (credit !== 4'(m_credit)) begin
            errors++;
            $display("FAIL coin_credit: credit=%0d, required %0d", credit, m_credit);
        end
        checks++;
        if (cnt_reject - b_rej !== exp_rej) begin
            errors++;
            $display("FAIL coin_reject_count: rejects=%0d, required %0d", cnt_reject - b_rej, exp_rej);
        end
    endtask

    task automatic do_cancel();
        int b_ref, exp_ref;
        b_ref   = cnt_refund;
        exp_ref = m_credit;
        cancel  = 1'b1;
        tick();
        cancel  = 1'b0;
        wait_idle(64);
        m_credit = 0;
        checks++;
        if (cnt_refund - b_ref !== exp_ref) begin
            errors++;
            $display("FAIL cancel_refunds: refund pulses=%0d, required %0d", cnt_refund - b_ref, exp_ref);
        end
        checks++;
        if (credit !== 4'd0) begin
            errors++;
            $display("FAIL cancel_credit: credit=%0d, required 0", credit);
        end
    endtask

    task automatic do_select(input logic [3:0] mask, input logic [3:0] empty, input int delay);
        int g, b_start, b_item, b_ref, n, exp_ref;
        g       = model_grant(mask, empty);
        b_start = cnt_start;
        b_item  = cnt_item;
        b_ref   = cnt_refund;
        exp_ref = 0;
        mech_ready  = 1'b1;
        sel_req     = mask;
        stock_empty = empty;
        tick();
        sel_req     = 4'b0;
        stock_empty = 4'b0;
        if (g < 0) begin
            tick();
            tick();
            checks++;
            if (cnt_start - b_start !== 0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL sel_ignored: starts=%0d busy=%0b, required starts=0 busy=0",
                         cnt_start - b_start, busy);
            end
            checks++;
            if (credit !== 4'(m_credit)) begin
                errors++;
                $display("FAIL sel_ignored_credit: credit=%0d, required %0d", credit, m_credit);
            end
        end else begin
            n = 0;
            tick();
            while (mech_start !== 1'b1 && n < 10) begin
                tick();
                n++;
            end
            checks++;
            if (mech_start !== 1'b1 || mech_slot !== 2'(g) || n != 0) begin
                errors++;
                $display("FAIL grant: start=%0b slot=%0d extra_wait=%0d, required start=1 slot=%0d extra_wait=0",
                         mech_start, mech_slot, n, g);
            end
            repeat (delay) tick();
            mech_done = 1'b1;
            tick();
            mech_done = 1'b0;
            m_credit = m_credit - PRICES[g];
            m_ptr    = (g + 1) % 4;
`ifdef AUTO_CHANGE_EN
            exp_ref  = m_credit;
            m_credit = 0;
`endif
            wait_idle(64);
            checks++;
            if (cnt_start - b_start !== 1 || cnt_item - b_item !== 1) begin
                errors++;
                $display("FAIL vend_pulses: starts=%0d items=%0d, required 1 and 1",
                         cnt_start - b_start, cnt_item - b_item);
            end
            checks++;
            if (credit !== 4'(m_credit) || cnt_refund - b_ref !== exp_ref) begin
                errors++;
                $display("FAIL vend_credit: credit=%0d refunds=%0d, required credit=%0d refunds=%0d",
                         credit, cnt_refund - b_ref, m_credit, exp_ref);
            end
        end
    endtask

    task automatic test_reset();
        int b_ref, n;
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if ({mech_start, item_out, refund_pulse, coin_reject, busy, fault} !== 6'b0 ||
            credit !== 4'd0 || mech_slot !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: flags=%b credit=%0d slot=%0d, required all 0",
                     {mech_start, item_out, refund_pulse, coin_reject, busy, fault}, credit, mech_slot);
        end
        rst = 1'b1;
        tick();
        m_credit = 0; m_ptr = 0; m_fault = 1'b0;
        insert_coins(4);
        b_ref  = cnt_refund;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        n = 0;
        while (cnt_refund - b_ref < 2 && n < 20) begin
            tick();
            n++;
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({mech_start, item_out, refund_pulse, coin_reject, busy, fault} !== 6'b0 || credit !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid_refund: flags=%b credit=%0d, required all 0",
                     {mech_start, item_out, refund_pulse, coin_reject, busy, fault}, credit);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        m_credit = 0; m_ptr = 0; m_fault = 1'b0;
        checks++;
        if (cnt_refund - b_ref !== 2 || busy !== 1'b0 || credit !== 4'd0) begin
            errors++;
            $display("FAIL reset_idle_after: refunds=%0d busy=%0b credit=%0d, required 2, 0, 0",
                     cnt_refund - b_ref, busy, credit);
        end
    endtask

    task automatic test_vend_basic();
        apply_reset();
        insert_coins(3);
        do_select(4'b0100, 4'b0000, 5);
        insert_coins(2);
        do_select(4'b1000, 4'b0000, 0);
        do_cancel();
    endtask

    task automatic test_round_robin();
`ifndef AUTO_CHANGE_EN
        int n, b_item;
        apply_reset();
        insert_coins(15);
        b_item     = cnt_item;
        mech_ready = 1'b1;
        sel_req    = 4'b0011;
        for (int v = 0; v < 2; v++) begin
            n = 0;
            tick();
            while (mech_start !== 1'b1 && n < 10) begin
                tick();
                n++;
            end
            checks++;
            if (mech_start !== 1'b1 || mech_slot !== 2'(v)) begin
                errors++;
                $display("FAIL rr_grant%0d: start=%0b slot=%0d, required start=1 slot=%0d",
                         v, mech_start, mech_slot, v);
            end
            if (v == 1) sel_req = 4'b0;
            mech_done = 1'b1;
            tick();
            mech_done = 1'b0;
        end
        wait_idle(16);
        m_credit = 12;
        m_ptr    = 2;
        checks++;
        if (credit !== 4'd12 || cnt_item - b_item !== 2) begin
            errors++;
            $display("FAIL rr_result: credit=%0d items=%0d, required 12 and 2", credit, cnt_item - b_item);
        end
        do_cancel();
`endif
    endtask

    task automatic test_coin_reject();
        int b_rej, b_start, n;
        apply_reset();
        insert_coins(16);
        mech_ready = 1'b0;
        sel_req    = 4'b0001;
        tick();
        sel_req = 4'b0;
        b_rej   = cnt_reject;
        b_start = cnt_start;
        coin_in = 1'b1;
        tick();
        coin_in = 1'b0;
        cancel  = 1'b1;
        tick();
        cancel  = 1'b0;
        tick();
        tick();
        checks++;
        if (cnt_reject - b_rej !== 1 || credit !== 4'd15) begin
            errors++;
            $display("FAIL busy_coin: rejects=%0d credit=%0d, required 1 and 15", cnt_reject - b_rej, credit);
        end
        checks++;
        if (busy !== 1'b1 || cnt_start - b_start !== 0 || cnt_refund < 0) begin
            errors++;
            $display("FAIL start_hold: busy=%0b starts=%0d, required busy=1 starts=0", busy, cnt_start - b_start);
        end
        mech_ready = 1'b1;
        n = 0;
        while (mech_start !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        mech_done = 1'b1;
        tick();
        mech_done = 1'b0;
        wait_idle(32);
        m_credit = 14;
        m_ptr    = 1;
`ifdef AUTO_CHANGE_EN
        m_credit = 0;
`endif
        checks++;
        if (credit !== 4'(m_credit)) begin
            errors++;
            $display("FAIL cancel_in_start: credit=%0d, required %0d", credit, m_credit);
        end
        do_cancel();
    endtask

    task automatic test_fault();
        int b_ref, n;
        apply_reset();
        insert_coins(6);
        b_ref      = cnt_refund;
        mech_ready = 1'b1;
        sel_req    = 4'b0001;
        tick();
        sel_req = 4'b0;
        n = 0;
        while (mech_start !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        n = 0;
        while (fault !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (fault !== 1'b1 || n != 32) begin
            errors++;
            $display("FAIL fault_timeout: fault=%0b after %0d cycles, required 1 after 32", fault, n);
        end
        m_fault = 1'b1;
        wait_idle(32);
        checks++;
        if (cnt_refund - b_ref !== 6 || credit !== 4'd0) begin
            errors++;
            $display("FAIL fault_refund: refunds=%0d credit=%0d, required 6 and 0", cnt_refund - b_ref, credit);
        end
        m_credit = 0;
        insert_coins(2);
        do_select(4'b0001, 4'b0000, 0);
        checks++;
        if (fault !== 1'b1) begin
            errors++;
            $display("FAIL fault_sticky: fault=%0b, required 1", fault);
        end
        apply_reset();
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_clear: fault=%0b, required 0", fault);
        end
    endtask

    task automatic test_auto_change();
        apply_reset();
        insert_coins(5);
        do_select(4'b0010, 4'b0000, 3);
        do_cancel();
    endtask

    task automatic test_random();
        int op;
        apply_reset();
        for (int it = 0; it < 60; it++) begin
            op = int'($urandom_range(0, 3));
            case (op)
                0, 1: insert_coins(int'($urandom_range(1, 6)));
                2: do_select(4'($urandom_range(1, 15)),
                             4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                             int'($urandom_range(0, 6)));
                default: do_cancel();
            endcase
        end
        do_cancel();
    endtask

    initial begin
        tick();
        test_reset();
        test_vend_basic();
        test_round_robin();
        test_coin_reject();
        test_fault();
        test_auto_change();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vend_dispense_sequencer.md
Name: vend_dispense_sequencer

Overview:
- Controller that sits between the coin/selection front panel and one shared dispense mechanism.
- Accumulates coin credit and arbitrates round-robin among NUM_SLOTS selection buttons; only affordable, in-stock slots compete.
- Sequences the mechanism through a start/done handshake, deducts the price, and returns coins one per cycle on cancel or fault.

Parameters:
- NUM_SLOTS, 4, number of item slots / selection buttons (2..8).
- CREDIT_W, 4, credit counter width; max credit = 2^CREDIT_W-1.
- PRICE_VEC, {4'd5,4'd3,4'd2,4'd1}, packed prices; slot i price = PRICE_VEC[i*CREDIT_W +: CREDIT_W]; a price of 0 disables the slot.
- MECH_TIMEOUT, 32, cycles allowed in WAIT_DONE before a fault.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- coin_in  in  1  one coin per cycle while high
- cancel  in  1  request refund of all credit
- sel_req  in  NUM_SLOTS  selection buttons, level
- stock_empty  in  NUM_SLOTS  slot empty flags
- mech_ready  in  1  mechanism can accept a start
- mech_done  in  1  one-cycle pulse, item delivered
- mech_start  out  1  one-cycle start pulse
- mech_slot  out  clog2(NUM_SLOTS)  slot being dispensed; valid from mech_start until done
- item_out  out  1  one-cycle pulse after successful vend
- refund_pulse  out  1  one coin returned per high cycle
- coin_reject  out  1  one-cycle pulse, coin not accepted
- credit  out  CREDIT_W  current credit
- busy  out  1  high in any state except IDLE
- fault  out  1  sticky mechanism timeout flag

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0; credit 0; round-robin pointer 0; timeout counter 0.
- All outputs are registered. Events sampled at cycle N appear at cycle N+1.
- States: IDLE, START, WAIT_DONE, REFUND.
- IDLE:
  - coin_in increments credit.
  - At max credit, the coin is not added and coin_reject pulses.
  - eligible[i] = sel_req[i] & ~stock_empty[i] & price_i!=0 & credit>=price_i.
  - Priority within a cycle: cancel > selection > coin.
  - cancel with credit>0 -> REFUND.
  - cancel with credit==0 -> stays IDLE.
  - Any cancel or selection in the same cycle as coin_in rejects the coin.
  - Any eligible slot -> grant the first eligible index at or after the pointer (wrapping), latch mech_slot, go to START.
  - A selection that is ineligible is silently ignored.
- START:
  - When mech_ready=1, pulse mech_start, go to WAIT_DONE.
  - Otherwise hold START.
  - cancel is ignored once a grant is made.
- WAIT_DONE:
  - On mech_done: credit -= price, item_out pulses next cycle, pointer = granted+1 mod NUM_SLOTS, then go to IDLE.
  - If MECH_TIMEOUT cycles elapse without mech_done: set fault (sticky), no deduction, go to REFUND.
- REFUND:
  - refund_pulse high while credit>0; credit decrements once per cycle.
  - When credit reaches 0, go to IDLE. refund_pulse count equals the credit on entry.
- Outside IDLE, coin_in always produces coin_reject and never changes credit.
- While fault=1, selections are ignored and coins are rejected; cancel and refund still work. Only reset clears fault.
- Credit never underflows, because the grant requires credit>=price.

Optional Feature:
- Macro AUTO_CHANGE_EN.
- Defined: after mech_done, if the remaining credit is >0, go straight to REFUND and return the change automatically.
- Undefined: remaining credit is retained in IDLE for further purchases or a later cancel.

Test Plan:
- Reset mid-refund: credit=4, cancel, drop rst after 2 refund_pulse -> all outputs 0 immediately, credit 0, state IDLE.
- 3 coins, sel_req=4'b0100 (price 3), mech_ready=1, mech_done 5 cycles later -> mech_start at +1 with mech_slot=2, item_out once, credit 0.
- 2 coins, sel_req=4'b1000 (price 5) -> no mech_start; cancel -> exactly 2 refund_pulse, credit 0.
- credit=15, sel_req=4'b0011 held across two vends, pointer at 0 -> slot 0 then slot 1 granted; credit ends 12.
- 15 coins then a 16th coin -> coin_reject pulses, credit stays 15; coin while busy -> coin_reject.
- Grant slot 0 with credit 6, mech_done never arrives -> fault=1 after 32 cycles, 6 refund_pulse, later selections ignored.
- With AUTO_CHANGE_EN: credit 5, buy slot 1 (price 2) -> item_out then 3 refund_pulse. Without it: credit stays 3.
